// File: rtl/carpma_hakemi_pkg.sv
// Shared opcodes, requester indices and the in-flight tag type
// used by the multiplier arbiter.
package carpma_hakemi_pkg;

  localparam logic [1:0] CARPMA_MUL    = 2'd0;
  localparam logic [1:0] CARPMA_MULH   = 2'd1;
  localparam logic [1:0] CARPMA_MULHU  = 2'd2;
  localparam logic [1:0] CARPMA_MULHSU = 2'd3;

  localparam int ISTEK_CEKIRDEK     = 0;
  localparam int ISTEK_HIZLANDIRICI = 1;
  localparam int ISTEK_SAYISI       = 2;

  localparam logic SAHIP_CEKIRDEK     = 1'b0;
  localparam logic SAHIP_HIZLANDIRICI = 1'b1;

  typedef struct packed {
    logic gecerli;
    logic sahip;
  } etiket_t;

  // Flush only ever kills core-owned work.
  function automatic etiket_t etiket_temizle(
    input etiket_t e,
    input logic    temizle
  );
    etiket_t r;
    r = e;
    if (temizle && (e.sahip == SAHIP_CEKIRDEK)) begin
      r.gecerli = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/carpma_hakemi_etiket.sv
// Tag shift register that mirrors the multiplier pipeline;
// frozen on stall, flush clears core-owned tags in place.
module carpma_hakemi_etiket
  import carpma_hakemi_pkg::*;
#(
  parameter int GECIKME = 1
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    ilerle_i,
  input  logic    temizle_i,
  input  etiket_t giris_i,
  output etiket_t son_o
);

  etiket_t etiket_q [GECIKME];
  etiket_t etiket_d [GECIKME];
  etiket_t kaydir   [GECIKME];

  always_comb begin
    kaydir[0] = ilerle_i ? giris_i : etiket_q[0];
    for (int i = 1; i < GECIKME; i++) begin
      kaydir[i] = ilerle_i ? etiket_q[i-1] : etiket_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < GECIKME; i++) begin
      etiket_d[i] = etiket_temizle(kaydir[i], temizle_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < GECIKME; i++) begin
        etiket_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < GECIKME; i++) begin
        etiket_q[i] <= etiket_d[i];
      end
    end
  end

  // Last stage sees the flush in the same cycle.
  assign son_o = etiket_temizle(etiket_q[GECIKME-1], temizle_i);

endmodule

// File: rtl/carpma_hakemi.sv
// Round-robin arbiter sharing one pipelined multiplier between
// the core and an accelerator, with in-order result return.
module carpma_hakemi
  import carpma_hakemi_pkg::*;
#(
  parameter int GECIKME = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       istek_gecerli_i,
  output logic [1:0]       istek_hazir_o,
  input  logic [1:0][1:0]  istek_kontrol_i,
  input  logic [1:0][31:0] istek_deger1_i,
  input  logic [1:0][31:0] istek_deger2_i,
  input  logic             temizle_i,
  output logic [1:0]       carpma_kontrol_o,
  output logic [31:0]      carpma_deger1_o,
  output logic [31:0]      carpma_deger2_o,
  output logic             carpma_durdur_o,
  input  logic [31:0]      carpma_sonuc_i,
  output logic [1:0]       sonuc_gecerli_o,
  output logic [31:0]      sonuc_o,
  input  logic [1:0]       sonuc_hazir_i
);

  logic       son_verilen_q;
  logic       son_verilen_d;
  logic [1:0] uygun;
  logic       sec0;
  logic       sec1;
  logic       verilen;
  etiket_t    yeni_etiket;
  etiket_t    son_etiket;

  always_comb begin
    carpma_durdur_o = son_etiket.gecerli
                    & ~sonuc_hazir_i[son_etiket.sahip];
  end

  always_comb begin
    uygun = istek_gecerli_i & {1'b1, ~temizle_i};
    if (rst_i || carpma_durdur_o) begin
      uygun = 2'b00;
    end
    // With both pending, the one not served last wins.
    sec0 = uygun[0] & (~uygun[1] | son_verilen_q);
    sec1 = uygun[1] & (~uygun[0] | ~son_verilen_q);
    istek_hazir_o = 2'b00;
    unique case (1'b1)
      sec0:    istek_hazir_o = 2'b01;
      sec1:    istek_hazir_o = 2'b10;
      default: istek_hazir_o = 2'b00;
    endcase
  end

  always_comb begin
    verilen          = istek_hazir_o[1];
    son_verilen_d    = son_verilen_q;
    yeni_etiket      = '0;
    carpma_kontrol_o = CARPMA_MUL;
    carpma_deger1_o  = '0;
    carpma_deger2_o  = '0;
    if (|istek_hazir_o) begin
      son_verilen_d       = verilen;
      yeni_etiket.gecerli = 1'b1;
      yeni_etiket.sahip   = verilen;
      carpma_kontrol_o    = istek_kontrol_i[verilen];
      carpma_deger1_o     = istek_deger1_i[verilen];
      carpma_deger2_o     = istek_deger2_i[verilen];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      son_verilen_q <= SAHIP_HIZLANDIRICI;
    end else begin
      son_verilen_q <= son_verilen_d;
    end
  end

  carpma_hakemi_etiket #(
    .GECIKME(GECIKME)
  ) u_etiket (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ilerle_i (~carpma_durdur_o),
    .temizle_i(temizle_i),
    .giris_i  (yeni_etiket),
    .son_o    (son_etiket)
  );

  always_comb begin
    sonuc_gecerli_o = 2'b00;
    sonuc_o         = '0;
    if (son_etiket.gecerli) begin
      sonuc_gecerli_o[son_etiket.sahip] = 1'b1;
      sonuc_o = carpma_sonuc_i;
    end
  end

endmodule
